// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus of the next-PC sequencer: PC/instruction from the fetch unit,
// hazard and redirect controls from D, and the IF/ID register contents.
interface fetch_sequencer_if;
  logic [31:0] pc_i;
  logic [31:0] instr_i;
  logic        stall;
  logic        fetch_hold;
  logic        redir_valid;
  logic [1:0]  redir_kind;
  logic        redir_taken;
  logic [15:0] br_imm16;
  logic [25:0] j_index;
  logic [31:0] jr_target;
  logic [31:0] next_pc;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic        d_valid;
  logic        pend_o;
  logic [31:0] fetch_count;

  // Environment side: fetch unit plus D-stage control.
  modport master (
    output pc_i, instr_i, stall, fetch_hold, redir_valid, redir_kind,
           redir_taken, br_imm16, j_index, jr_target,
    input  next_pc, d_instr, d_pc, d_valid, pend_o, fetch_count
  );

  // Sequencer side.
  modport slave (
    input  pc_i, instr_i, stall, fetch_hold, redir_valid, redir_kind,
           redir_taken, br_imm16, j_index, jr_target,
    output next_pc, d_instr, d_pc, d_valid, pend_o, fetch_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Next-PC sequencer and IF/ID stage register for the pipelined MIPS core.
// Resolves stalls, fetch holds and D-stage redirects with delay-slot semantics;
// a redirect that arrives while fetch is held is parked in PEND until the
// delay slot can be fetched.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP      = 32'h0000_0000
) (
  input logic          clk,
  input logic          reset,
  fetch_sequencer_if.slave bus
);

  typedef enum logic {S_RUN, S_PEND} state_t;

  state_t      state_q, state_d;
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic [31:0] d_instr_q, d_instr_d;
  logic [31:0] d_pc_q, d_pc_d;
  logic        d_valid_q, d_valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic [31:0] d_pc_plus4;
  logic [31:0] br_off;
  logic [31:0] tgt;
  logic        redir_now;
  logic [31:0] next_pc;

  // Redirect target of the instruction currently in D, and whether it redirects now.
  always_comb begin
    d_pc_plus4 = d_pc_q + 32'd4;
    br_off     = {{14{bus.br_imm16[15]}}, bus.br_imm16, 2'b00};
    case (bus.redir_kind)
      2'b00:   tgt = d_pc_plus4 + br_off;
      2'b01:   tgt = {d_pc_plus4[31:28], bus.j_index, 2'b00};
      2'b10:   tgt = bus.jr_target & ~32'd3;
      default: tgt = d_pc_plus4;
    endcase
    redir_now = bus.redir_valid & ~bus.stall &
                ((bus.redir_kind == 2'b01) | (bus.redir_kind == 2'b10) |
                 ((bus.redir_kind == 2'b00) & bus.redir_taken));
  end

  // Next-PC selection, IF/ID load and FSM next state, in priority order.
  always_comb begin
    state_d       = state_q;
    pend_tgt_d    = pend_tgt_q;
    d_instr_d     = d_instr_q;
    d_pc_d        = d_pc_q;
    d_valid_d     = d_valid_q;
    fetch_count_d = fetch_count_q;
    next_pc       = bus.pc_i;

    if (reset) begin
      next_pc = RESET_PC;
    end else if (bus.stall) begin
      next_pc = bus.pc_i;
    end else if (bus.fetch_hold) begin
      // Bubble into ID; d_pc is kept so a redirect decoded now still targets correctly.
      next_pc   = bus.pc_i;
      d_instr_d = NOP;
      d_valid_d = 1'b0;
      if (state_q == S_RUN && redir_now) begin
        state_d    = S_PEND;
        pend_tgt_d = tgt;
      end
    end else if (state_q == S_PEND) begin
      // Delay slot arrives now; redirect inputs are ignored since D holds a bubble.
      next_pc       = pend_tgt_q;
      d_instr_d     = bus.instr_i;
      d_pc_d        = bus.pc_i;
      d_valid_d     = 1'b1;
      fetch_count_d = fetch_count_q + 32'd1;
      state_d       = S_RUN;
    end else begin
      next_pc       = redir_now ? tgt : bus.pc_i + 32'd4;
      d_instr_d     = bus.instr_i;
      d_pc_d        = bus.pc_i;
      d_valid_d     = 1'b1;
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  // State and IF/ID registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_RUN;
      pend_tgt_q    <= '0;
      d_instr_q     <= NOP;
      d_pc_q        <= RESET_PC;
      d_valid_q     <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pend_tgt_q    <= pend_tgt_d;
      d_instr_q     <= d_instr_d;
      d_pc_q        <= d_pc_d;
      d_valid_q     <= d_valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.next_pc     = next_pc;
  assign bus.d_instr     = d_instr_q;
  assign bus.d_pc        = d_pc_q;
  assign bus.d_valid     = d_valid_q;
  assign bus.pend_o      = (state_q == S_PEND);
  assign bus.fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a simple fetch-unit model feeds pc_i/instr_i
// back from next_pc; expected values are hand-computed constants.
module tb_fetch_sequencer;

  logic clk = 1'b0;
  logic reset;
  logic [31:0] fpc = 32'h0000_3000;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  fetch_sequencer_if bus ();

  fetch_sequencer #(
    .RESET_PC(32'h0000_3000),
    .NOP     (32'h0000_0000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Fetch unit model: PC register loaded from next_pc, instruction tagged by PC.
  always @(posedge clk) fpc <= bus.next_pc;
  assign bus.pc_i    = fpc;
  assign bus.instr_i = {16'hC0DE, fpc[15:0]};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    bus.stall       = 1'b0;
    bus.fetch_hold  = 1'b0;
    bus.redir_valid = 1'b0;
    bus.redir_kind  = 2'b00;
    bus.redir_taken = 1'b0;
    bus.br_imm16    = 16'h0000;
    bus.j_index     = 26'h0;
    bus.jr_target   = 32'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clr_in();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    clr_in();
    #1;
    check_eq("rst_next_pc", bus.next_pc, 32'h3000);
    tick();
    tick();
    check_eq("rst_d_instr", bus.d_instr, 32'h0);
    check_eq("rst_d_pc", bus.d_pc, 32'h3000);
    check_eq("rst_d_valid", {31'b0, bus.d_valid}, 32'd0);
    check_eq("rst_pend", {31'b0, bus.pend_o}, 32'd0);
    check_eq("rst_count", bus.fetch_count, 32'd0);
    reset = 1'b0;

    // 1: free run
    for (int unsigned i = 0; i < 4; i++) begin
      #1;
      check_eq("run_next_pc", bus.next_pc, 32'h3004 + 32'(4 * i));
      tick();
      check_eq("run_d_pc", bus.d_pc, 32'h3000 + 32'(4 * i));
      check_eq("run_d_instr", bus.d_instr, 32'hC0DE_3000 + 32'(4 * i));
    end
    check_eq("run_count", bus.fetch_count, 32'd4);

    // 2: taken beq at d_pc=3008, imm=FFFE -> 300C - 8 = 3004
    do_reset();
    run(3);
    check_eq("beq_setup_d_pc", bus.d_pc, 32'h3008);
    bus.redir_valid = 1'b1; bus.redir_kind = 2'b00; bus.redir_taken = 1'b1;
    bus.br_imm16 = 16'hFFFE;
    #1;
    check_eq("beq_t_next_pc", bus.next_pc, 32'h3004);
    tick();
    clr_in();
    check_eq("beq_slot_d_pc", bus.d_pc, 32'h300C);
    check_eq("beq_slot_instr", bus.d_instr, 32'hC0DE_300C);
    check_eq("beq_slot_valid", {31'b0, bus.d_valid}, 32'd1);
    #1;
    check_eq("beq_after_next", bus.next_pc, 32'h3008);
    tick();
    check_eq("beq_tgt_d_pc", bus.d_pc, 32'h3004);

    // 3: same beq not taken
    do_reset();
    run(3);
    bus.redir_valid = 1'b1; bus.redir_kind = 2'b00; bus.redir_taken = 1'b0;
    bus.br_imm16 = 16'hFFFE;
    #1;
    check_eq("beq_nt_next_pc", bus.next_pc, 32'h3010);
    tick();
    clr_in();
    check_eq("beq_nt_pend", {31'b0, bus.pend_o}, 32'd0);
    check_eq("beq_nt_valid", {31'b0, bus.d_valid}, 32'd1);
    check_eq("beq_nt_d_pc", bus.d_pc, 32'h300C);

    // 4: jal / jr / reserved kind at d_pc=3004
    do_reset();
    run(2);
    bus.redir_valid = 1'b1; bus.redir_kind = 2'b01; bus.j_index = 26'h0000C10;
    #1;
    check_eq("jal_next_pc", bus.next_pc, 32'h0000_3040);
    bus.redir_kind = 2'b10; bus.jr_target = 32'h0000_3043;
    #1;
    check_eq("jr_next_pc", bus.next_pc, 32'h0000_3040);
    bus.jr_target = 32'h1234_5677;
    #1;
    check_eq("jr_align", bus.next_pc, 32'h1234_5674);
    bus.redir_kind = 2'b11;
    #1;
    check_eq("kind11_next_pc", bus.next_pc, 32'h300C);
    bus.redir_kind = 2'b01;
    tick();
    clr_in();
    check_eq("jal_slot_d_pc", bus.d_pc, 32'h3008);
    #1;
    check_eq("jal_tgt_next", bus.next_pc, 32'h3044);

    // 5: taken beq (3008 + 4 + 5*4 = 3020) under fetch_hold for 2 cycles
    do_reset();
    run(3);
    bus.redir_valid = 1'b1; bus.redir_kind = 2'b00; bus.redir_taken = 1'b1;
    bus.br_imm16 = 16'h0005; bus.fetch_hold = 1'b1;
    #1;
    check_eq("hold_next_pc", bus.next_pc, 32'h300C);
    tick();
    check_eq("hold1_pend", {31'b0, bus.pend_o}, 32'd1);
    check_eq("hold1_valid", {31'b0, bus.d_valid}, 32'd0);
    check_eq("hold1_instr", bus.d_instr, 32'h0);
    check_eq("hold1_d_pc", bus.d_pc, 32'h3008);
    // redirect inputs in PEND are ignored
    bus.redir_kind = 2'b01; bus.j_index = 26'h0000400;
    #1;
    check_eq("hold2_next_pc", bus.next_pc, 32'h300C);
    tick();
    check_eq("hold2_pend", {31'b0, bus.pend_o}, 32'd1);
    check_eq("hold2_valid", {31'b0, bus.d_valid}, 32'd0);
    check_eq("hold2_count", bus.fetch_count, 32'd3);
    bus.fetch_hold = 1'b0;
    #1;
    check_eq("pend_next_pc", bus.next_pc, 32'h3020);
    tick();
    clr_in();
    check_eq("pend_slot_d_pc", bus.d_pc, 32'h300C);
    check_eq("pend_slot_valid", {31'b0, bus.d_valid}, 32'd1);
    check_eq("pend_exit", {31'b0, bus.pend_o}, 32'd0);
    check_eq("pend_count", bus.fetch_count, 32'd4);
    #1;
    check_eq("pend_tgt_next", bus.next_pc, 32'h3024);

    // 6: stall with redirect (and once with fetch_hold) -> full freeze
    do_reset();
    run(3);
    bus.redir_valid = 1'b1; bus.redir_kind = 2'b00; bus.redir_taken = 1'b1;
    bus.br_imm16 = 16'h0005; bus.stall = 1'b1;
    for (int unsigned i = 0; i < 3; i++) begin
      bus.fetch_hold = (i == 1);
      #1;
      check_eq("stall_next_pc", bus.next_pc, 32'h300C);
      tick();
      check_eq("stall_d_pc", bus.d_pc, 32'h3008);
      check_eq("stall_d_instr", bus.d_instr, 32'hC0DE_3008);
      check_eq("stall_count", bus.fetch_count, 32'd3);
      check_eq("stall_pend", {31'b0, bus.pend_o}, 32'd0);
    end
    clr_in();
    #1;
    check_eq("unstall_next", bus.next_pc, 32'h3010);

    // reset while in PEND
    bus.redir_valid = 1'b1; bus.redir_taken = 1'b1; bus.br_imm16 = 16'h0005;
    bus.fetch_hold = 1'b1;
    tick();
    check_eq("rp_pend", {31'b0, bus.pend_o}, 32'd1);
    reset = 1'b1;
    clr_in();
    #1;
    check_eq("rp_next_pc", bus.next_pc, 32'h3000);
    tick();
    check_eq("rp_pend_clr", {31'b0, bus.pend_o}, 32'd0);
    check_eq("rp_count", bus.fetch_count, 32'd0);
    reset = 1'b0;
    #1;
    check_eq("rp_restart", bus.next_pc, 32'h3004);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
